piso_bit_driver: RTL and testbench
==================================

Name: piso_bit_driver

Overview:
- Upstream feeder for the serial sequence-detector FSMs in the finite-state-machine collection.
- Accepts a parallel word over a valid/ready handshake.
- Shifts the word out MSB-first, one bit per clock, on a serial line that drives a detector's `a` input.
- Provides framing flags (`sout_valid`, `done`) so benches and downstream stages can align detector output with the transmitted word.

Parameters:
- WIDTH, 8, number of data bits per word (legal range 2..32).
- CNT_W, $clog2(WIDTH), bit-counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset, sampled on the clk rising edge.
- din  input  WIDTH  parallel word to transmit.
- din_valid  input  1  din holds a word to load.
- din_ready  output  1  block can accept a word this cycle.
- sout  output  1  serial bit; connects to a detector's `a` input.
- sout_valid  output  1  sout carries a real data (or parity) bit this cycle.
- busy  output  1  a word is being shifted.
- done  output  1  one-cycle pulse during the final bit of a word.

Behaviour:
- Interface decision: one clock (clk); reset (rst) is synchronous and active-high.
- Reset while rst is high at a clk edge:
  - state=IDLE, shift register=0, counter=0.
  - sout=0, sout_valid=0, busy=0, done=0.
  - din_ready is forced to 0 while rst is high.
- Reset mid-word aborts the word; no further bits of it are driven.
- States: IDLE, SHIFT; PARITY exists only with the optional feature.
- IDLE:
  - din_ready=1, sout=0, sout_valid=0.
  - On din_valid&&din_ready: load din into the shift register, counter=WIDTH-1, next state SHIFT.
- SHIFT:
  - sout=shreg[WIDTH-1], sout_valid=1, busy=1.
  - Each clk: shift left by 1 (zero fill) and decrement the counter.
- Last bit of SHIFT (counter==0): done=1, din_ready=1.
  - If din_valid is high, load the new word and stay in SHIFT with counter=WIDTH-1. This gives gapless back-to-back streaming.
  - Otherwise go to IDLE.
- All other SHIFT cycles: din_ready=0. din_valid is ignored and the word is not consumed.
- Latency: a word accepted at edge N puts its MSB on sout during cycle N+1. The LSB appears during cycle N+WIDTH.
- Throughput: one word per WIDTH cycles when streaming.
- Outputs derive only from registered state; there is no combinational path from din or din_valid to sout.
- Counter never wraps. An underflow past 0 is a design error; the bench asserts it never occurs.
- Simultaneous rst and din_valid: reset wins and the word is not accepted.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After the LSB, the block enters PARITY for one cycle.
  - In PARITY: sout = even parity (XOR) of the loaded word, sout_valid=1, busy=1.
  - done and din_ready move from the last data bit to the PARITY cycle; back-to-back load happens from PARITY.
  - Throughput: one word per WIDTH+1 cycles.
  - The parity value is computed from din at load time and held in a register.
- Undefined: no PARITY state or parity register; behaviour is exactly as described above.

Decomposition:
- Shared package piso_pkg holds:
  - State encoding localparams: ST_IDLE=2'b00, ST_SHIFT=2'b01, ST_PARITY=2'b10.
  - Default WIDTH constant.
- The same encoding style is reused by the detector FSMs.
- One natural sub-module: piso_bit_counter. It is a loadable down-counter with load, en and a zero flag, instantiated once.

Test Plan:
- Reset, then one word:
  - Hold rst for 2 clks: all outputs 0, din_ready=0.
  - Release rst: din_ready=1.
  - Load din=8'hA5 → sout sequence 1,0,1,0,0,1,0,1 on cycles N+1..N+8, sout_valid high for exactly 8 cycles, done on cycle N+8.
- Back-to-back:
  - Words 8'hFF then 8'h00, with din_valid held high.
  - Required: 16 contiguous sout_valid cycles, sout 8×1 then 8×0, din_ready high only on cycles 8 and 16.
- Handshake hold-off: din_valid pulsed mid-word (bit 3) → word not consumed, current word unchanged, din_ready=0.
- Reset mid-word: assert rst during bit 4 of 8'hC3 → next cycle sout_valid=0 and IDLE; a following word 8'h81 transmits cleanly as 1,0,0,0,0,0,0,1.
- Detector integration:
  - Connect sout→a on a 101 detector and send 8'b0101_0000.
  - Required: detector y asserts at the cycle positions given by the detector's state spec; the bench checks against its model.
- PISO_PARITY_EN defined:
  - din=8'h07 → parity bit 1 on cycle N+9, done on N+9.
  - din=8'h03 → parity bit 0.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out bit driver: state encoding
// and the default word width.
package piso_pkg;

    localparam int PISO_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SHIFT  = 2'b01,
        ST_PARITY = 2'b10
    } piso_state_t;

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter with a zero flag; tracks the remaining bits of a word.
module piso_bit_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_value,
    output logic             zero
);

    logic [CNT_W-1:0] count_reg;

    // The counter saturates at zero so it can never wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (en && (count_reg != '0)) begin
            count_reg <= count_reg - CNT_W'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/piso_bit_driver.sv
// Parallel-in/serial-out driver: accepts a word on valid/ready and shifts it out
// MSB first. Define PISO_PARITY_EN to append an even-parity bit after each word.
module piso_bit_driver
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);

    piso_state_t      state_reg;
    logic [WIDTH-1:0] shreg_reg;
    logic             cnt_zero;
    logic             last_bit;
    logic             accept_slot;
    logic             load;
`ifdef PISO_PARITY_EN
    logic             parity_reg;
`endif

    piso_bit_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .en        (state_reg == ST_SHIFT),
        .load_value(CNT_W'(WIDTH - 1)),
        .zero      (cnt_zero)
    );

    assign last_bit = (state_reg == ST_SHIFT) && cnt_zero;

    // The acceptance slot is the final serial cycle of a word, so a word loaded
    // there follows the previous one with no gap.
`ifdef PISO_PARITY_EN
    assign accept_slot = (state_reg == ST_IDLE) || (state_reg == ST_PARITY);
    assign done        = (state_reg == ST_PARITY);
`else
    assign accept_slot = (state_reg == ST_IDLE) || last_bit;
    assign done        = last_bit;
`endif

    assign din_ready  = !rst && accept_slot;
    assign load       = din_valid && din_ready;
    assign sout_valid = (state_reg != ST_IDLE);
    assign busy       = (state_reg != ST_IDLE);

    always_comb begin
        sout = 1'b0;
        case (state_reg)
            ST_SHIFT:  sout = shreg_reg[WIDTH-1];
`ifdef PISO_PARITY_EN
            ST_PARITY: sout = parity_reg;
`endif
            default:   sout = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            shreg_reg <= '0;
`ifdef PISO_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else if (load) begin
            state_reg <= ST_SHIFT;
            shreg_reg <= din;
`ifdef PISO_PARITY_EN
            parity_reg <= ^din;
`endif
        end else begin
            case (state_reg)
                ST_SHIFT: begin
                    shreg_reg <= shreg_reg << 1;
                    if (cnt_zero) begin
`ifdef PISO_PARITY_EN
                        state_reg <= ST_PARITY;
`else
                        state_reg <= ST_IDLE;
`endif
                    end
                end
                ST_PARITY: state_reg <= ST_IDLE;
                default:   state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piso_bit_driver.sv
// Self-checking bench for piso_bit_driver: directed scenarios plus random traffic
// compared against a queue-of-expected-serial-bits reference model.
module tb_piso_bit_driver;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready;
    logic         sout;
    logic         sout_valid;
    logic         busy;
    logic         done;

    int errors = 0;
    int checks = 0;

    // Reference model: bits still to appear on sout, head = current cycle.
    bit exp_q[$];
    // Bits actually observed on sout while sout_valid was high.
    bit stream[$];

    piso_bit_driver #(
        .WIDTH(W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .sout      (sout),
        .sout_valid(sout_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // One clock cycle: apply inputs, check outputs mid-cycle, advance the model.
    task automatic cycle(input logic r, input logic v, input logic [W-1:0] d);
        logic e_valid;
        logic e_sout;
        logic e_done;
        logic e_ready;
        logic accept;
        rst       = r;
        din_valid = v;
        din       = d;
        e_valid = (exp_q.size() != 0);
        e_sout  = e_valid ? exp_q[0] : 1'b0;
        e_done  = (exp_q.size() == 1);
        e_ready = !r && (exp_q.size() <= 1);
        @(negedge clk);
        check("sout", sout, e_sout);
        check("sout_valid", sout_valid, e_valid);
        check("busy", busy, e_valid);
        check("done", done, e_done);
        check("din_ready", din_ready, e_ready);
        if (sout_valid === 1'b1) stream.push_back(sout);
        @(posedge clk);
        if (r) begin
            exp_q.delete();
        end else begin
            accept = v && (exp_q.size() <= 1);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            if (accept) begin
                for (int i = W - 1; i >= 0; i--) exp_q.push_back(d[i]);
`ifdef PISO_PARITY_EN
                exp_q.push_back(^d);
`endif
            end
        end
        #1;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 4 * W && exp_q.size() != 0; k++) cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);
    endtask

    initial begin
        logic [W-1:0] det_mask;
        logic [W-1:0] word;
        rst       = 1'b1;
        din_valid = 1'b0;
        din       = '0;
        @(posedge clk);
        #1;

        // Reset held for two clocks, then a single word 8'hA5.
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, 8'hFF);
        cycle(1'b0, 1'b1, 8'hA5);
        wait_idle();

        // Back-to-back 8'hFF then 8'h00 with din_valid held high.
        cycle(1'b0, 1'b1, 8'hFF);
        for (int i = 0; i < W; i++) cycle(1'b0, 1'b1, 8'h00);
        wait_idle();

        // din_valid pulsed during bit 3 must not be consumed.
        cycle(1'b0, 1'b1, 8'h3C);
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 8'hE7);
        wait_idle();

        // Reset during bit 4 of 8'hC3, then a clean 8'h81.
        cycle(1'b0, 1'b1, 8'hC3);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
        cycle(1'b0, 1'b1, 8'h81);
        wait_idle();

        // Detector integration: overlapping "101" detector on the serial stream.
        stream.delete();
        cycle(1'b0, 1'b1, 8'b0101_0000);
        wait_idle();
        det_mask = '0;
        if (stream.size() >= W) begin
            for (int i = 2; i < W; i++)
                if (stream[i-2] == 1'b1 && stream[i-1] == 1'b0 && stream[i] == 1'b1)
                    det_mask[W-1-i] = 1'b1;
        end
        checks++;
        assert (stream.size() >= W) else begin
            errors++;
            $error("FAIL det_len: observed=%0d expected>=%0d", stream.size(), W);
        end
        checks++;
        assert (det_mask === 8'b0001_0000) else begin
            errors++;
            $error("FAIL det_hits: observed=%b expected=%b", det_mask, 8'b0001_0000);
        end

        // Parity-relevant words (parity 1 and parity 0 when the feature is built).
        cycle(1'b0, 1'b1, 8'h07);
        wait_idle();
        cycle(1'b0, 1'b1, 8'h03);
        wait_idle();

        // Random traffic with occasional resets.
        for (int n = 0; n < 500; n++) begin
            word = W'($urandom);
            cycle($urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0, word);
        end
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
